// File: rtl/iic_cmd_queue.sv
// Command FIFO plus retry sequencer in front of iic_drive.
// Each accepted command produces exactly one response, and responses come back in FIFO order.
module iic_cmd_queue #(
    parameter int DEPTH     = 8,
    parameter int AW        = 3,
    parameter int MAX_RETRY = 2,
    parameter int BUSY_WAIT = 15,
    parameter int RETRY_GAP = 100
) (
    input  logic          clk_i,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_wr_rd,
    input  logic [7:0]    cmd_dev_addr,
    input  logic [15:0]   cmd_reg,
    input  logic [7:0]    cmd_data,
    output logic          wr_rd_flag,
    output logic          start_en,
    output logic [7:0]    i2c_device_addr,
    output logic [15:0]   register,
    output logic [7:0]    data_byte,
    input  logic          busy,
    input  logic          err,
    input  logic [7:0]    rd_data,
    output logic          rsp_valid,
    output logic          rsp_err,
    output logic [7:0]    rsp_rd_data,
    output logic [15:0]   rsp_reg,
    output logic [AW:0]   queue_level,
    output logic          q_busy
);

    localparam int WW = (BUSY_WAIT > 0) ? $clog2(BUSY_WAIT + 1) : 1;
    localparam int GW = (RETRY_GAP > 0) ? $clog2(RETRY_GAP + 1) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT_H, S_WAIT_L, S_CHECK, S_GAP, S_RESP
    } state_t;

    logic [32:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q, level_d;
    logic          ready_q;
    logic          push, pop;

    state_t        state_q;
    logic [32:0]   cmd_q;
    logic [7:0]    rd_q;
    logic          fail_q;
    logic [RW-1:0] retry_q;
    logic [WW-1:0] wait_q;
    logic [GW-1:0] gap_q;
    logic          wr_rd_q, start_q;
    logic [7:0]    dev_q, data_q;
    logic [15:0]   reg_q;
    logic          rsp_valid_q, rsp_err_q;
    logic [7:0]    rsp_rd_q;
    logic [15:0]   rsp_reg_q;

    assign push = cmd_valid & ready_q;
    assign pop  = (state_q == S_IDLE) && (level_q != '0) && !busy;

    always_comb begin
        level_d = level_q;
        if (push && !pop)
            level_d = level_q + (AW+1)'(1);
        else if (!push && pop)
            level_d = level_q - (AW+1)'(1);
    end

    always_ff @(posedge clk_i) begin
        if (push)
            mem_q[wr_ptr_q] <= {cmd_wr_rd, cmd_dev_addr, cmd_reg, cmd_data};
    end

    // cmd_ready is registered from the next level, so a push on the last free slot drops it at once
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
            ready_q <= (level_d != FULL);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            rd_q        <= '0;
            fail_q      <= 1'b0;
            retry_q     <= '0;
            wait_q      <= '0;
            gap_q       <= '0;
            wr_rd_q     <= 1'b0;
            start_q     <= 1'b0;
            dev_q       <= '0;
            reg_q       <= '0;
            data_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rd_q    <= '0;
            rsp_reg_q   <= '0;
        end else begin
            start_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        cmd_q   <= mem_q[rd_ptr_q];
                        retry_q <= '0;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    {wr_rd_q, dev_q, reg_q, data_q} <= cmd_q;
                    start_q <= 1'b1;
                    state_q <= S_START;
                end
                S_START: begin
                    wait_q  <= WW'(BUSY_WAIT);
                    fail_q  <= 1'b0;
                    state_q <= S_WAIT_H;
                end
                S_WAIT_H: begin
                    if (busy) begin
                        state_q <= S_WAIT_L;
                    end else if (wait_q == '0) begin
                        fail_q  <= 1'b1;
                        state_q <= S_CHECK;
                    end else begin
                        wait_q <= wait_q - WW'(1);
                    end
                end
                S_WAIT_L: begin
                    if (!busy) begin
                        fail_q  <= err;
                        rd_q    <= rd_data;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (fail_q && (retry_q < RW'(MAX_RETRY))) begin
                        retry_q <= retry_q + RW'(1);
                        gap_q   <= GW'(RETRY_GAP);
                        state_q <= S_GAP;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= fail_q;
                        rsp_rd_q    <= (wr_rd_q && !fail_q) ? rd_q : 8'h00;
                        rsp_reg_q   <= reg_q;
                        state_q     <= S_RESP;
                    end
                end
                S_GAP: begin
                    if (gap_q == '0) begin
                        start_q <= 1'b1;
                        state_q <= S_START;
                    end else begin
                        gap_q <= gap_q - GW'(1);
                    end
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready       = ready_q;
    assign queue_level     = level_q;
    assign q_busy          = (level_q != '0) || (state_q != S_IDLE);
    assign wr_rd_flag      = wr_rd_q;
    assign start_en        = start_q;
    assign i2c_device_addr = dev_q;
    assign register        = reg_q;
    assign data_byte       = data_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_err         = rsp_err_q;
    assign rsp_rd_data     = rsp_rd_q;
    assign rsp_reg         = rsp_reg_q;

endmodule

// File: doc/iic_cmd_queue.md
Name: iic_cmd_queue

Overview:
Command queue and retry sequencer sitting directly upstream of iic_drive, in place of or alongside iic_reg_init. It buffers up to DEPTH I2C register transactions from any requester and issues them one at a time over the iic_drive start_en/busy/err handshake. It retries failed transfers up to MAX_RETRY times and returns one response per command, carrying read data and error status. Runs in the clk_i domain, the same slow clock that drives iic_drive.

Parameters:
DEPTH, 8, command FIFO entries (power of two)
AW, 3, log2(DEPTH)
MAX_RETRY, 2, extra attempts after the first failure (0 = no retry)
BUSY_WAIT, 15, clk_i cycles allowed for busy to rise after start_en
RETRY_GAP, 100, idle clk_i cycles between a failed attempt and its retry

Ports:
clk_i  in  1  block clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  requester has a command
cmd_ready  out  1  queue can accept; transfer on cmd_valid&cmd_ready
cmd_wr_rd  in  1  0 write, 1 read
cmd_dev_addr  in  8  I2C device address
cmd_reg  in  16  register address
cmd_data  in  8  write data (ignored for reads)
wr_rd_flag  out  1  to iic_drive
start_en  out  1  to iic_drive, one-cycle pulse
i2c_device_addr  out  8  to iic_drive
register  out  16  to iic_drive
data_byte  out  8  to iic_drive
busy  in  1  from iic_drive
err  in  1  from iic_drive, valid at busy falling edge
rd_data  in  8  from iic_drive
rsp_valid  out  1  one-cycle response strobe
rsp_err  out  1  command failed after all retries
rsp_rd_data  out  8  read byte (0 for writes or failures)
rsp_reg  out  16  register address of the completed command
queue_level  out  AW+1  FIFO occupancy, 0..DEPTH
q_busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM IDLE; cmd_ready=1 from the first cycle after reset release.
- FIFO: width 33 bits {wr_rd, dev, reg, data}; cmd_ready = (level != DEPTH). A push while full is impossible by handshake. Simultaneous push and pop keep level unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, LOAD, START, WAIT_H, WAIT_L, CHECK, GAP, RESP.
- IDLE: when the FIFO is non-empty and busy=0, pop the head into holding registers -> LOAD. Clear the retry counter.
- LOAD: drive wr_rd_flag, i2c_device_addr, register and data_byte from the holding registers. These outputs stay stable until the command's response is issued -> START.
- START: start_en=1 for exactly this cycle; load the wait counter with BUSY_WAIT -> WAIT_H.
- WAIT_H: on busy=1 -> WAIT_L. If the counter expires with busy still 0, treat the attempt as failed -> CHECK with a fail flag.
- WAIT_L: on busy=0, capture err into the fail flag and rd_data into the holding registers -> CHECK. There is no timeout in this state; iic_drive guarantees busy drops.
- CHECK:
  - Not failed -> RESP.
  - Failed and retry count < MAX_RETRY: increment the retry count, load the gap counter with RETRY_GAP -> GAP.
  - Failed otherwise -> RESP with error.
- GAP: count down to 0 -> START. The command is re-issued; it is not popped again.
- RESP: rsp_valid=1 for one cycle with rsp_reg and rsp_err. rsp_rd_data = captured byte if read and OK, else 0 -> IDLE.
- Latency: at minimum, 2 cycles from IDLE pop to start_en. Back-to-back commands have at least 1 IDLE cycle between RESP and the next LOAD.
- Total attempts per command = 1 + MAX_RETRY at most. Exactly one rsp_valid per accepted command, in FIFO order.
- rst_n asserted mid-transfer: FIFO flushed, FSM to IDLE, no response emitted. iic_drive is reset by the same rst_n.
- rsp_* hold their last values between strobes; only rsp_valid pulses.

Test Plan:
1. Reset, push 1 write {dev 0x60, reg 0x3008, data 0x82}; model busy high for 40 cycles, err=0 -> start_en exactly once. Outputs show 0x60/0x3008/0x82/wr_rd=0. rsp_valid once with rsp_err=0, rsp_rd_data=0x00.
2. Push read {0x61, 0x300A}; model returns rd_data=0x56, err=0 -> rsp_rd_data=0x56, rsp_err=0, rsp_reg=0x300A.
3. Push write; model asserts err=1 on the first two attempts and 0 on the third -> 3 start_en pulses, each at least RETRY_GAP cycles apart; single rsp_valid with rsp_err=0.
4. Model never raises busy -> start_en pulses 3 times, each after a BUSY_WAIT timeout; rsp_err=1, rsp_rd_data=0.
5. Hold busy=1 in the model, push 9 commands back-to-back -> cmd_ready drops after 8 with queue_level=8. Release busy -> 8 responses in order, with rsp_reg matching push order.
6. Assert rst_n low during WAIT_L with 3 commands queued -> queue_level=0, start_en=0, no rsp_valid; cmd_ready=1 after release.
